// File: rtl/m_wb_ioctrl_pkg.sv
// Shared definitions for the Wishbone I/O controller.
// Contents:
//   NSLAVE       number of I/O slaves behind the controller
//   IDXW         width of the slave index taken from the address
//   state_t      controller FSM states (IDLE/ACTIVE/DONE)
//   onehot()     slave index -> one-hot strobe vector
package m_wb_ioctrl_pkg;

    localparam int NSLAVE = 4;
    localparam int IDXW   = $clog2(NSLAVE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    function automatic logic [NSLAVE-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NSLAVE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/m_wb_ioctrl_if.sv
// Bus bundle for the Wishbone I/O controller: the core-side (m_*) port and
// the fanned-out slave-side (s_*) port.
// Modports:
//   ctrl    the controller itself
//   master  the bus master (midgetv core) driving requests
//   slave   the I/O slaves returning ACK and read data
// Handshake: a request is valid while m_CYC_I & m_STB_I are high; it is held
// until m_ACK_O pulses for one cycle and dropped in the cycle after. On the
// slave side s_STB_O (one-hot) is the valid and s_ACK_I[n] is the completion
// from slave n; s_ACK_I bits of non-selected slaves carry no meaning.
interface m_wb_ioctrl_if;
    import m_wb_ioctrl_pkg::*;

    logic                     m_CYC_I;
    logic                     m_STB_I;
    logic                     m_WE_I;
    logic [31:0]              m_ADR_I;
    logic [31:0]              m_DAT_I;
    logic [3:0]               m_SEL_I;
    logic [31:0]              m_DAT_O;
    logic                     m_ACK_O;

    logic                     s_CYC_O;
    logic [NSLAVE-1:0]        s_STB_O;
    logic                     s_WE_O;
    logic [31:0]              s_ADR_O;
    logic [31:0]              s_DAT_O;
    logic [3:0]               s_SEL_O;
    logic [NSLAVE-1:0]        s_ACK_I;
    logic [32*NSLAVE-1:0]     s_DAT_I;

    modport ctrl (
        input  m_CYC_I, m_STB_I, m_WE_I, m_ADR_I, m_DAT_I, m_SEL_I,
        output m_DAT_O, m_ACK_O,
        output s_CYC_O, s_STB_O, s_WE_O, s_ADR_O, s_DAT_O, s_SEL_O,
        input  s_ACK_I, s_DAT_I
    );

    modport master (
        output m_CYC_I, m_STB_I, m_WE_I, m_ADR_I, m_DAT_I, m_SEL_I,
        input  m_DAT_O, m_ACK_O
    );

    modport slave (
        input  s_CYC_O, s_STB_O, s_WE_O, s_ADR_O, s_DAT_O, s_SEL_O,
        output s_ACK_I, s_DAT_I
    );

endinterface

// File: rtl/m_wb_timeout.sv
// Bus timeout counter.
// Ports:
//   CLK_I, RST_I  clock, asynchronous active-low reset
//   clr           zero the counter (wins over en)
//   en            count up one per cycle
//   tc            high while the counter sits at its terminal value
// The terminal value is 2^TOWIDTH-2: the counter is cleared on entry to the
// wait, so tc is reached in the (2^TOWIDTH-1)-th waiting cycle.
module m_wb_timeout #(
    parameter int TOWIDTH = 4
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TOWIDTH-1:0] TC_VAL = TOWIDTH'((2 ** TOWIDTH) - 2);

    logic [TOWIDTH-1:0] cnt;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TOWIDTH'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/m_wb_ioctrl.sv
// Wishbone I/O controller between the core's bus master port and up to four
// I/O slaves. Decodes the slave index from the address, latches the request,
// strobes the chosen slave and returns a one-cycle master ACK. Slaves flagged
// in FIXEDACK are acknowledged after one wait state; the others must raise
// their own ACK before the timeout, else the cycle ends with zero read data
// and a bus-error pulse.
// Ports:
//   CLK_I, RST_I  clock, asynchronous active-low reset
//   bus           core-side and slave-side Wishbone signals (ctrl modport)
//   buserr_O      one-cycle pulse on a timed-out access (same cycle as ACK)
//   errcnt_O      saturating count of timed-out accesses
//   dbg_state     current FSM state
module m_wb_ioctrl
    import m_wb_ioctrl_pkg::*;
#(
    parameter int                DECODEBIT = 28,
    parameter logic [NSLAVE-1:0] FIXEDACK  = 4'b0011,
    parameter int                TOWIDTH   = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    m_wb_ioctrl_if.ctrl       bus,
    output logic              buserr_O,
    output logic [7:0]        errcnt_O,
    output state_t            dbg_state
);

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   req_idx;
    logic              accept;
    logic              to_tc;
    logic              sel_ack;
    logic              sel_fixed;
    logic [31:0]       sel_dat;

    assign req_idx   = bus.m_ADR_I[DECODEBIT+1:DECODEBIT];
    assign accept    = (state == ST_IDLE) && bus.m_CYC_I && bus.m_STB_I;
    assign sel_ack   = bus.s_ACK_I[idx];
    assign sel_fixed = FIXEDACK[idx];
    assign sel_dat   = bus.s_DAT_I[32*idx +: 32];
    assign dbg_state = state;

    m_wb_timeout #(
        .TOWIDTH (TOWIDTH)
    ) u_timeout (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .clr   (accept),
        .en    (state == ST_ACTIVE),
        .tc    (to_tc)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state       <= ST_IDLE;
            idx         <= '0;
            bus.m_DAT_O <= '0;
            bus.m_ACK_O <= 1'b0;
            bus.s_CYC_O <= 1'b0;
            bus.s_STB_O <= '0;
            bus.s_WE_O  <= 1'b0;
            bus.s_ADR_O <= '0;
            bus.s_DAT_O <= '0;
            bus.s_SEL_O <= '0;
            buserr_O    <= 1'b0;
            errcnt_O    <= '0;
        end else begin
            // ACK and error are single-cycle pulses unless re-raised below.
            bus.m_ACK_O <= 1'b0;
            buserr_O    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx         <= req_idx;
                        bus.s_WE_O  <= bus.m_WE_I;
                        bus.s_ADR_O <= bus.m_ADR_I;
                        bus.s_DAT_O <= bus.m_DAT_I;
                        bus.s_SEL_O <= bus.m_SEL_I;
                        bus.s_CYC_O <= 1'b1;
                        bus.s_STB_O <= onehot(req_idx);
                        state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // Priority: abort, then completion, then timeout, so an
                    // ACK on the terminal-count cycle still completes cleanly.
                    if (!bus.m_CYC_I) begin
                        bus.s_CYC_O <= 1'b0;
                        bus.s_STB_O <= '0;
                        state       <= ST_IDLE;
                    end else if (sel_fixed || sel_ack) begin
                        if (!bus.s_WE_O) begin
                            bus.m_DAT_O <= sel_dat;
                        end
                        bus.m_ACK_O <= 1'b1;
                        bus.s_CYC_O <= 1'b0;
                        bus.s_STB_O <= '0;
                        state       <= ST_DONE;
                    end else if (to_tc) begin
                        bus.m_DAT_O <= '0;
                        bus.m_ACK_O <= 1'b1;
                        buserr_O    <= 1'b1;
                        if (errcnt_O != 8'hFF) begin
                            errcnt_O <= errcnt_O + 8'd1;
                        end
                        bus.s_CYC_O <= 1'b0;
                        bus.s_STB_O <= '0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_wb_ioctrl.sv
// Self-checking bench for m_wb_ioctrl: directed scenarios plus randomized
// accesses predicted by a cycle-count model of the controller's rules.
module tb_m_wb_ioctrl;
    import m_wb_ioctrl_pkg::*;

    localparam int          TOW        = 4;
    localparam logic [3:0]  FIXED      = 4'b0011;
    localparam int          ACTIVE_MAX = (1 << TOW) - 1;

    // ---------------- clock / reset ----------------
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        buserr;
    logic [7:0]  errcnt;
    state_t      dbg_state;

    m_wb_ioctrl_if bus();

    m_wb_ioctrl #(
        .DECODEBIT (28),
        .FIXEDACK  (FIXED),
        .TOWIDTH   (TOW)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .bus       (bus),
        .buserr_O  (buserr),
        .errcnt_O  (errcnt),
        .dbg_state (dbg_state)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_dat  = '0;
    int          exp_err  = 0;
    logic [31:0] exp_q[$];

    // Cycle (counted from the request-sampling edge) in which m_ACK_O shows.
    function automatic int model_ack(input int idx, input int ack_cyc);
        if (FIXED[idx]) return 2;
        if (ack_cyc >= 1 && ack_cyc <= ACTIVE_MAX) return ack_cyc + 1;
        return ACTIVE_MAX + 1;
    endfunction

    function automatic bit model_err(input int idx, input int ack_cyc);
        return !FIXED[idx] && !(ack_cyc >= 1 && ack_cyc <= ACTIVE_MAX);
    endfunction

    function automatic void model_update(input int idx, input bit we, input int ack_cyc,
                                         input logic [31:0] sdat);
        if (model_err(idx, ack_cyc)) begin
            exp_dat = '0;
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else if (!we) begin
            exp_dat = sdat;
        end
        exp_q.push_back(exp_dat);
    endfunction

    // ---------------- driver ----------------
    task automatic idle_bus();
        bus.m_CYC_I = 1'b0;
        bus.m_STB_I = 1'b0;
        bus.m_WE_I  = 1'b0;
        bus.m_ADR_I = '0;
        bus.m_DAT_I = '0;
        bus.m_SEL_I = '0;
        bus.s_ACK_I = '0;
        bus.s_DAT_I = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK_I);
        @(negedge CLK_I);
    endtask

    // Runs one access from IDLE. The addressed slave raises its ACK in active
    // cycle ack_cyc (0 = never); other slaves' ACK bits toggle randomly.
    task automatic run_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int ack_cyc, input logic [31:0] sdat,
                              output int ack_at, output logic err_at_ack,
                              output logic [3:0] stb_c1, output logic cyc_c1);
        int           idx;
        logic [3:0]   noise;
        logic [127:0] sd;
        idx         = int'(adr[29:28]);
        ack_at      = -1;
        err_at_ack  = 1'b0;
        stb_c1      = '0;
        cyc_c1      = 1'b0;
        bus.m_CYC_I = 1'b1;
        bus.m_STB_I = 1'b1;
        bus.m_WE_I  = we;
        bus.m_ADR_I = adr;
        bus.m_DAT_I = dat;
        bus.m_SEL_I = sel;
        bus.s_ACK_I = '0;
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            next_cycle();
            if (c == 1) begin
                stb_c1 = bus.s_STB_O;
                cyc_c1 = bus.s_CYC_O;
            end
            if (bus.m_ACK_O) begin
                ack_at     = c;
                err_at_ack = buserr;
                idle_bus();
            end else begin
                noise      = 4'($urandom_range(0, 15));
                noise[idx] = (c == ack_cyc);
                sd         = {$urandom(), $urandom(), $urandom(), $urandom()};
                sd[idx*32 +: 32] = sdat;
                bus.s_ACK_I = noise;
                bus.s_DAT_I = sd;
            end
        end
        idle_bus();
        next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (bus.m_ACK_O !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.m_ACK_O); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== 32'h0) $display("FAIL reset_dat: got %h want 0", bus.m_DAT_O); else n_pass++;
        n_checks++; if (bus.s_STB_O !== 4'h0) $display("FAIL reset_stb: got %b want 0000", bus.s_STB_O); else n_pass++;
        n_checks++; if (bus.s_CYC_O !== 1'b0) $display("FAIL reset_cyc: got %b want 0", bus.s_CYC_O); else n_pass++;
        n_checks++; if (errcnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", errcnt); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    endtask

    task automatic test_fixed_write();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        run_access(1'b1, 32'h0000_0000, 32'h0000_000E, 4'hF, 0, 32'h1234_5678, ack_at, err, stb, cyc);
        model_update(0, 1'b1, 0, 32'h1234_5678);
        n_checks++; if (stb !== 4'b0001) $display("FAIL fw_stb: got %b want 0001", stb); else n_pass++;
        n_checks++; if (cyc !== 1'b1) $display("FAIL fw_cyc: got %b want 1", cyc); else n_pass++;
        n_checks++; if (bus.s_DAT_O !== 32'hE) $display("FAIL fw_sdat: got %h want 0000000e", bus.s_DAT_O); else n_pass++;
        n_checks++; if (bus.s_WE_O !== 1'b1) $display("FAIL fw_swe: got %b want 1", bus.s_WE_O); else n_pass++;
        n_checks++; if (ack_at !== 2) $display("FAIL fw_ack_cycle: got %0d want 2", ack_at); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== exp_q.pop_front()) $display("FAIL fw_mdat: got %h want %h", bus.m_DAT_O, exp_dat); else n_pass++;
        n_checks++; if (bus.m_ACK_O !== 1'b0) $display("FAIL fw_ack_pulse: got %b want 0", bus.m_ACK_O); else n_pass++;
    endtask

    task automatic test_slave_read();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        run_access(1'b0, 32'h2000_0000, 32'h0, 4'hF, 4, 32'hDEAD_BEEF, ack_at, err, stb, cyc);
        model_update(2, 1'b0, 4, 32'hDEAD_BEEF);
        n_checks++; if (stb !== 4'b0100) $display("FAIL sr_stb: got %b want 0100", stb); else n_pass++;
        n_checks++; if (ack_at !== 5) $display("FAIL sr_ack_cycle: got %0d want 5", ack_at); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL sr_err: got %b want 0", err); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== exp_q.pop_front()) $display("FAIL sr_mdat: got %h want deadbeef", bus.m_DAT_O); else n_pass++;
    endtask

    task automatic test_timeout();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        run_access(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'hCAFE_F00D, ack_at, err, stb, cyc);
        model_update(3, 1'b0, 0, 32'hCAFE_F00D);
        n_checks++; if (ack_at !== ACTIVE_MAX + 1) $display("FAIL to_ack_cycle: got %0d want %0d", ack_at, ACTIVE_MAX + 1); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL to_err: got %b want 1", err); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== exp_q.pop_front()) $display("FAIL to_mdat: got %h want 0", bus.m_DAT_O); else n_pass++;
        n_checks++; if (errcnt !== 8'(exp_err)) $display("FAIL to_errcnt: got %0d want %0d", errcnt, exp_err); else n_pass++;
        n_checks++; if (buserr !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", buserr); else n_pass++;
    endtask

    task automatic test_tc_race();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        run_access(1'b0, 32'h3000_0010, 32'h0, 4'hF, ACTIVE_MAX, 32'h0BAD_CAFE, ack_at, err, stb, cyc);
        model_update(3, 1'b0, ACTIVE_MAX, 32'h0BAD_CAFE);
        n_checks++; if (ack_at !== ACTIVE_MAX + 1) $display("FAIL race_ack_cycle: got %0d want %0d", ack_at, ACTIVE_MAX + 1); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL race_err: got %b want 0", err); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== exp_q.pop_front()) $display("FAIL race_mdat: got %h want 0badcafe", bus.m_DAT_O); else n_pass++;
        n_checks++; if (errcnt !== 8'(exp_err)) $display("FAIL race_errcnt: got %0d want %0d", errcnt, exp_err); else n_pass++;
    endtask

    task automatic test_random();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        int idx; logic we; int ack_cyc; logic [31:0] adr; logic [31:0] sdat; logic [31:0] want;
        for (int i = 0; i < 40; i++) begin
            idx     = $urandom_range(0, 3);
            we      = 1'($urandom_range(0, 1));
            ack_cyc = $urandom_range(1, ACTIVE_MAX + 2);
            adr     = $urandom();
            adr[29:28] = 2'(idx);
            sdat    = $urandom();
            run_access(we, adr, $urandom(), 4'($urandom_range(0, 15)), ack_cyc, sdat, ack_at, err, stb, cyc);
            model_update(idx, we, ack_cyc, sdat);
            want = exp_q.pop_front();
            n_checks++; if (stb !== 4'(1 << idx)) $display("FAIL rnd_stb[%0d]: got %b want %b", i, stb, 4'(1 << idx)); else n_pass++;
            n_checks++; if (ack_at !== model_ack(idx, ack_cyc)) $display("FAIL rnd_ack_cycle[%0d]: got %0d want %0d", i, ack_at, model_ack(idx, ack_cyc)); else n_pass++;
            n_checks++; if (err !== 1'(model_err(idx, ack_cyc))) $display("FAIL rnd_err[%0d]: got %b want %b", i, err, model_err(idx, ack_cyc)); else n_pass++;
            n_checks++; if (bus.m_DAT_O !== want) $display("FAIL rnd_mdat[%0d]: got %h want %h", i, bus.m_DAT_O, want); else n_pass++;
            n_checks++; if (errcnt !== 8'(exp_err)) $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", i, errcnt, exp_err); else n_pass++;
        end
    endtask

    // Drop CYC in active cycle 2 while slave 2 ACKs in that same cycle.
    task automatic test_abort();
        logic [31:0] dat_before;
        logic [7:0]  cnt_before;
        dat_before  = exp_dat;
        cnt_before  = 8'(exp_err);
        bus.m_CYC_I = 1'b1;
        bus.m_STB_I = 1'b1;
        bus.m_WE_I  = 1'b0;
        bus.m_ADR_I = 32'h2000_0040;
        next_cycle();
        n_checks++; if (bus.s_STB_O !== 4'b0100) $display("FAIL ab_stb_on: got %b want 0100", bus.s_STB_O); else n_pass++;
        next_cycle();
        bus.m_CYC_I = 1'b0;
        bus.m_STB_I = 1'b0;
        bus.s_ACK_I = 4'b0100;
        bus.s_DAT_I = {4{32'h5555_AAAA}};
        next_cycle();
        bus.s_ACK_I = '0;
        n_checks++; if (bus.s_STB_O !== 4'b0000) $display("FAIL ab_stb_off: got %b want 0000", bus.s_STB_O); else n_pass++;
        n_checks++; if (bus.s_CYC_O !== 1'b0) $display("FAIL ab_cyc_off: got %b want 0", bus.s_CYC_O); else n_pass++;
        n_checks++; if (bus.m_ACK_O !== 1'b0) $display("FAIL ab_ack0: got %b want 0", bus.m_ACK_O); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL ab_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        next_cycle();
        n_checks++; if (bus.m_ACK_O !== 1'b0) $display("FAIL ab_ack1: got %b want 0", bus.m_ACK_O); else n_pass++;
        n_checks++; if (buserr !== 1'b0) $display("FAIL ab_err: got %b want 0", buserr); else n_pass++;
        n_checks++; if (errcnt !== cnt_before) $display("FAIL ab_errcnt: got %0d want %0d", errcnt, cnt_before); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== dat_before) $display("FAIL ab_mdat: got %h want %h", bus.m_DAT_O, dat_before); else n_pass++;
        idle_bus();
    endtask

    task automatic test_errcnt_saturate();
        int ack_at; logic err; logic [3:0] stb; logic cyc;
        for (int i = 0; i < 300; i++) begin
            run_access(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h0, ack_at, err, stb, cyc);
            model_update(3, 1'b0, 0, 32'h0);
            void'(exp_q.pop_front());
        end
        n_checks++; if (errcnt !== 8'(exp_err)) $display("FAIL sat_errcnt: got %0d want %0d", errcnt, exp_err); else n_pass++;
        n_checks++; if (errcnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", errcnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ack_at; logic err; logic [3:0] stb; logic cyc; logic [31:0] sdat;
        sdat = $urandom() | 32'h1;
        run_access(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, sdat, ack_at, err, stb, cyc);
        model_update(1, 1'b0, 0, sdat);
        n_checks++; if (bus.m_DAT_O !== exp_q.pop_front()) $display("FAIL rm_pre_mdat: got %h want %h", bus.m_DAT_O, sdat); else n_pass++;
        bus.m_CYC_I = 1'b1;
        bus.m_STB_I = 1'b1;
        bus.m_WE_I  = 1'b1;
        bus.m_ADR_I = 32'h3000_0ABC;
        bus.m_DAT_I = 32'hFFFF_FFFF;
        bus.m_SEL_I = 4'hF;
        next_cycle();
        next_cycle();
        #2 RST_I = 1'b0;
        #1;
        exp_dat = '0;
        exp_err = 0;
        n_checks++; if (bus.s_STB_O !== 4'h0) $display("FAIL rm_stb: got %b want 0000", bus.s_STB_O); else n_pass++;
        n_checks++; if (bus.s_CYC_O !== 1'b0) $display("FAIL rm_cyc: got %b want 0", bus.s_CYC_O); else n_pass++;
        n_checks++; if (bus.s_ADR_O !== 32'h0) $display("FAIL rm_sadr: got %h want 0", bus.s_ADR_O); else n_pass++;
        n_checks++; if (bus.s_DAT_O !== 32'h0) $display("FAIL rm_sdat: got %h want 0", bus.s_DAT_O); else n_pass++;
        n_checks++; if (bus.m_DAT_O !== exp_dat) $display("FAIL rm_mdat: got %h want 0", bus.m_DAT_O); else n_pass++;
        n_checks++; if (errcnt !== 8'(exp_err)) $display("FAIL rm_errcnt: got %0d want 0", errcnt); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rm_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        idle_bus();
        @(negedge CLK_I);
        RST_I = 1'b1;
        next_cycle();
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rm_post_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        n_checks++; if (bus.m_ACK_O !== 1'b0) $display("FAIL rm_post_ack: got %b want 0", bus.m_ACK_O); else n_pass++;
        run_access(1'b1, 32'h0000_0004, 32'h0000_0077, 4'h1, 0, 32'h0, ack_at, err, stb, cyc);
        n_checks++; if (ack_at !== 2) $display("FAIL rm_recover_ack: got %0d want 2", ack_at); else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        idle_bus();
        repeat (3) @(negedge CLK_I);
        test_reset();
        RST_I = 1'b1;
        next_cycle();
        test_reset();
        test_fixed_write();
        test_slave_read();
        test_timeout();
        test_tc_race();
        test_random();
        test_abort();
        test_errcnt_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
